// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div over a fixed
// busy window and commits the result latched at start when the window ends.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOP,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    input  logic        MD_RD,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_OUT
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_hi_p, r_lo_p;
    logic        r_dz;

    logic [63:0] w_smul, w_umul;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_ua, w_ub, w_ub_nz, w_uq, w_ur, w_q, w_r;
    logic [31:0] w_hi_n, w_lo_n;
    logic        w_is_mul, w_is_div;

    assign w_is_mul = (MDOP == OP_MULT) || (MDOP == OP_MULTU);
    assign w_is_div = (MDOP == OP_DIV)  || (MDOP == OP_DIVU);

    // Signed product via sign extension to 64 bits; the low 64 bits are exact.
    assign w_smul = {{32{MD_A[31]}}, MD_A} * {{32{MD_B[31]}}, MD_B};
    assign w_umul = {32'd0, MD_A} * {32'd0, MD_B};

    // Signed divide done on magnitudes, so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg = (MDOP == OP_DIV) && MD_A[31];
    assign w_b_neg = (MDOP == OP_DIV) && MD_B[31];
    assign w_ua    = w_a_neg ? (32'd0 - MD_A) : MD_A;
    assign w_ub    = w_b_neg ? (32'd0 - MD_B) : MD_B;
    assign w_ub_nz = (w_ub == 32'd0) ? 32'd1 : w_ub;
    assign w_uq    = w_ua / w_ub_nz;
    assign w_ur    = w_ua % w_ub_nz;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_a_neg ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_hi_n = w_r;
        w_lo_n = w_q;
        case (MDOP)
            OP_MULT:  {w_hi_n, w_lo_n} = w_smul;
            OP_MULTU: {w_hi_n, w_lo_n} = w_umul;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    if (w_is_mul || w_is_div) begin
                        r_hi_p  <= w_hi_n;
                        r_lo_p  <= w_lo_n;
                        r_dz    <= w_is_div && (MD_B == 32'd0);
                        r_cnt   <= w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        r_state <= RUN;
                    end else if (MDOP == OP_MTHI) begin
                        r_hi <= MD_A;
                    end else if (MDOP == OP_MTLO) begin
                        r_lo <= MD_A;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        // Divide by zero still burns the full latency but leaves HI/LO alone.
                        if (!r_dz) begin
                            r_hi <= r_hi_p;
                            r_lo <= r_lo_p;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MD_OUT = MD_RD ? r_lo : r_hi;
endmodule
